// File: rtl/sqroot_iter.sv
// Iterative unsigned square root using the restoring digit-by-digit method.
// One root bit is produced per clock, MSB first. The result is held in DONE
// until the consumer takes it. The remainder always refers to the floor root,
// while the reported root can optionally be rounded to nearest.
module sqroot_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   n,
  input  logic               round_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem,
  output logic               exact
);

  localparam int RW = WIDTH / 2;
  localparam int CW = $clog2(RW + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LOAD = CW'(RW);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [CW-1:0] CNT_STEP = CW'(1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_radicand;
  logic             r_round;
  logic [RW-1:0]    r_q;
  logic [RW+1:0]    r_r;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_root;
  logic [RW:0]      r_rem;
  logic             r_exact;

  logic [RW+1:0]    w_rShift;
  logic [RW+1:0]    w_trial;
  logic             w_fits;
  logic [RW+1:0]    w_rNext;
  logic [RW-1:0]    w_qNext;
  logic [RW:0]      w_remFinal;
  logic             w_roundUp;
  logic [RW-1:0]    w_rootFinal;

  // One restoring step: bring down the next radicand pair, try subtracting 4q+1,
  // and derive the final (optionally rounded, saturating) root for the last step.
  always_comb begin
    w_rShift    = (r_r << 2) | {{RW{1'b0}}, r_radicand[WIDTH-1 -: 2]};
    w_trial     = {r_q, 2'b01};
    w_fits      = (w_rShift >= w_trial);
    w_rNext     = w_fits ? (w_rShift - w_trial) : w_rShift;
    w_qNext     = {r_q[RW-2:0], w_fits};
    w_remFinal  = w_rNext[RW:0];
    w_roundUp   = r_round && (w_remFinal > {1'b0, w_qNext}) && !(&w_qNext);
    w_rootFinal = w_roundUp ? (w_qNext + RW'(1)) : w_qNext;
  end

  // Control FSM plus iteration registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_radicand <= '0;
      r_round    <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_cnt      <= '0;
      r_root     <= '0;
      r_rem      <= '0;
      r_exact    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_radicand <= n;
            r_round    <= round_en;
            r_q        <= '0;
            r_r        <= '0;
            r_cnt      <= CNT_LOAD;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_radicand <= {r_radicand[WIDTH-3:0], 2'b00};
          r_q        <= w_qNext;
          r_r        <= w_rNext;
          r_cnt      <= r_cnt - CNT_STEP;
          if (r_cnt == CNT_LAST) begin
            r_root  <= w_rootFinal;
            r_rem   <= w_remFinal;
            r_exact <= (w_remFinal == '0);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign root      = r_root;
  assign rem       = r_rem;
  assign exact     = r_exact;

endmodule
